palette_ctl: RTL and testbench

PALETTE_CTL -- requirements
Module: palette_ctl

---
 rtl/palette_pkg.sv | 28 ++
 rtl/palette_rgb_expand.sv | 24 ++
 rtl/palette_ctl.sv | 138 +++++++++++++
 tb/tb_palette_ctl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared definitions for the palette controller: colour byte layout,
// index width, write-slot states and the stall counter sizing helper.
package palette_pkg;

  localparam int IdxW  = 4;
  localparam int ColW  = 8;
  localparam int CompW = 4;

  // Colour byte is {B[7:6], G[5:3], R[2:0]}
  localparam int RPos = 0;
  localparam int RW   = 3;
  localparam int GPos = 3;
  localparam int GW   = 3;
  localparam int BPos = 6;
  localparam int BW   = 2;

  localparam int StallMaxDefault = 255;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } slotState_e;

  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/palette_rgb_expand.sv
// Widens a packed palette byte into three 4-bit colour components by
// replicating the top bits of each field.
module palette_rgb_expand
  import palette_pkg::*;
(
  input  logic [ColW-1:0]  colour_i,
  output logic [CompW-1:0] r_o,
  output logic [CompW-1:0] g_o,
  output logic [CompW-1:0] b_o
);

  logic [RW-1:0] rField;
  logic [GW-1:0] gField;
  logic [BW-1:0] bField;

  assign rField = colour_i[RPos +: RW];
  assign gField = colour_i[GPos +: GW];
  assign bField = colour_i[BPos +: BW];

  assign r_o = {rField, rField[RW-1]};
  assign g_o = {gField, gField[GW-1]};
  assign b_o = {bField, bField};

endmodule

// File: rtl/palette_ctl.sv
// Palette RAM controller: shares one RAM port between the pixel lookup
// pipeline and a single-entry CPU write slot with bounded starvation.
module palette_ctl
  import palette_pkg::*;
#(
  parameter int STALL_MAX = StallMaxDefault
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_stb,
  input  logic [IdxW-1:0]  wr_idx,
  input  logic [ColW-1:0]  wr_data,
  output logic             wr_busy,
  input  logic             pix_valid,
  input  logic [IdxW-1:0]  pix_idx,
  output logic [IdxW-1:0]  ram_ad,
  output logic [ColW-1:0]  ram_din,
  output logic             ram_ce,
  output logic             ram_oce,
  output logic             ram_wre,
  input  logic [ColW-1:0]  ram_dout,
  output logic             rgb_valid,
  output logic [CompW-1:0] rgb_r,
  output logic [CompW-1:0] rgb_g,
  output logic [CompW-1:0] rgb_b
);

  localparam int            CntW       = cntWidth(STALL_MAX);
  localparam logic [CntW-1:0] StallLimit = CntW'(STALL_MAX);

  slotState_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [ColW-1:0]  data_q, data_d;
  logic [CntW-1:0]  stallCnt_q, stallCnt_d;

  logic             rdValid_q;
  logic             stolen_q;
  logic             rgbValid_q;
  logic [CompW-1:0] rgbR_q, rgbG_q, rgbB_q;
  logic [3*CompW-1:0] lastColour_q;

  logic             pending;
  logic             steal;
  logic             doWrite;
  logic             doRead;
  logic [CompW-1:0] expR, expG, expB;

  assign pending = (state_q == PENDING);
  assign steal   = pending & pix_valid & (stallCnt_q == StallLimit);
  assign doWrite = pending & (~pix_valid | steal);
  // Pixel reads are combinational from the inputs, so reset must mask them
  assign doRead  = pix_valid & ~steal & reset_n;

  always_comb begin
    ram_ad  = '0;
    ram_din = '0;
    if (doWrite) begin
      ram_ad  = idx_q;
      ram_din = data_q;
    end else if (doRead) begin
      ram_ad  = pix_idx;
    end
  end

  assign ram_ce  = doWrite | doRead;
  assign ram_wre = doWrite;
  assign ram_oce = 1'b1;
  assign wr_busy = pending;

  // A strobe always lands in the slot; draining with a strobe re-arms it
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    stallCnt_d = stallCnt_q;
    if (wr_stb) begin
      idx_d   = wr_idx;
      data_d  = wr_data;
      state_d = PENDING;
    end else if (doWrite) begin
      state_d = EMPTY;
    end
    if (!pending || doWrite) begin
      stallCnt_d = '0;
    end else begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  palette_rgb_expand uExpand (
    .colour_i (ram_dout),
    .r_o      (expR),
    .g_o      (expG),
    .b_o      (expB)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      idx_q        <= '0;
      data_q       <= '0;
      stallCnt_q   <= '0;
      rdValid_q    <= 1'b0;
      stolen_q     <= 1'b0;
      rgbValid_q   <= 1'b0;
      rgbR_q       <= '0;
      rgbG_q       <= '0;
      rgbB_q       <= '0;
      lastColour_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      stallCnt_q <= stallCnt_d;
      rdValid_q  <= doRead;
      stolen_q   <= steal;
      // A stolen pixel slot repeats the last real colour rather than RAM data
      if (rdValid_q) begin
        rgbValid_q               <= 1'b1;
        {rgbR_q, rgbG_q, rgbB_q} <= {expR, expG, expB};
        lastColour_q             <= {expR, expG, expB};
      end else if (stolen_q) begin
        rgbValid_q               <= 1'b1;
        {rgbR_q, rgbG_q, rgbB_q} <= lastColour_q;
      end else begin
        rgbValid_q               <= 1'b0;
        {rgbR_q, rgbG_q, rgbB_q} <= '0;
      end
    end
  end

  assign rgb_valid = rgbValid_q;
  assign rgb_r     = rgbR_q;
  assign rgb_g     = rgbG_q;
  assign rgb_b     = rgbB_q;

endmodule

// File: tb/tb_palette_ctl.sv
// Directed bench for palette_ctl with a behavioural synchronous palette RAM.
module tb_palette_ctl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_stb;
  logic [3:0] wr_idx;
  logic [7:0] wr_data;
  logic       wr_busy;
  logic       pix_valid;
  logic [3:0] pix_idx;
  logic [3:0] ram_ad;
  logic [7:0] ram_din;
  logic       ram_ce, ram_oce, ram_wre;
  logic [7:0] ram_dout = 8'h00;
  logic       rgb_valid;
  logic [3:0] rgb_r, rgb_g, rgb_b;

  logic [7:0] mem [16] = '{default: 8'h00};
  logic [13:0] ramBus;
  logic [12:0] rgbBus;

  int nCompared   = 0;
  int nMismatched = 0;

  assign ramBus = {ram_ce, ram_wre, ram_ad, ram_din};
  assign rgbBus = {rgb_valid, rgb_r, rgb_g, rgb_b};

  always #5 clk = ~clk;

  palette_ctl #(.STALL_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_stb    (wr_stb),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_busy   (wr_busy),
    .pix_valid (pix_valid),
    .pix_idx   (pix_idx),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_dout  (ram_dout),
    .rgb_valid (rgb_valid),
    .rgb_r     (rgb_r),
    .rgb_g     (rgb_g),
    .rgb_b     (rgb_b)
  );

  // Write-through synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) begin
        mem[ram_ad] <= ram_din;
        ram_dout    <= ram_din;
      end else begin
        ram_dout    <= mem[ram_ad];
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stb, input logic [3:0] wi, input logic [7:0] wd,
                       input logic pv, input logic [3:0] pi);
    wr_stb    = stb;
    wr_idx    = wi;
    wr_data   = wd;
    pix_valid = pv;
    pix_idx   = pi;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd6);
    #1;
    nCompared++;
    if ({wr_busy, rgbBus} !== 14'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got %h want %h", {wr_busy, rgbBus}, 14'd0);
    end
    nCompared++;
    if ({ram_oce, ramBus} !== {1'b1, 14'd0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_ram: got %h want %h", {ram_oce, ramBus}, {1'b1, 14'd0});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if ({wr_busy, rgbBus, ram_ce} !== 15'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got %h want %h", {wr_busy, rgbBus, ram_ce}, 15'd0);
    end
    stepCycle();
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd3, 8'hFF, 1'b0, 4'd0);
    nCompared++;
    if ({wr_busy, ram_ce} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL wr_latch: got %b want %b", {wr_busy, ram_ce}, 2'b00);
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if ({wr_busy, ramBus} !== {1'b1, 1'b1, 1'b1, 4'd3, 8'hFF}) begin
      nMismatched++;
      $display("[TB] FAIL wr_issue: got %h want %h", {wr_busy, ramBus}, {1'b1, 1'b1, 1'b1, 4'd3, 8'hFF});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    nCompared++;
    if ({wr_busy, ramBus[13:8], rgbBus} !== {1'b0, 1'b1, 1'b0, 4'd3, 13'd0}) begin
      nMismatched++;
      $display("[TB] FAIL rd_issue: got %h want %h", {wr_busy, ramBus[13:8], rgbBus}, {1'b0, 1'b1, 1'b0, 4'd3, 13'd0});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if (rgbBus !== 13'd0) begin
      nMismatched++;
      $display("[TB] FAIL rd_early: got %h want %h", rgbBus, 13'd0);
    end
    stepCycle();
    nCompared++;
    if (rgbBus !== {1'b1, 4'hF, 4'hF, 4'hF}) begin
      nMismatched++;
      $display("[TB] FAIL rd_white: got %h want %h", rgbBus, {1'b1, 4'hF, 4'hF, 4'hF});
    end
    stepCycle();
    nCompared++;
    if (rgbBus !== 13'd0) begin
      nMismatched++;
      $display("[TB] FAIL rd_idle_zero: got %h want %h", rgbBus, 13'd0);
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      drive(logic'(c == 0), 4'd5, 8'h07, 1'b1, 4'd3);
      nCompared++;
      if ({wr_busy, ramBus[13:8]} !== {logic'(c != 0), 1'b1, 1'b0, 4'd3}) begin
        nMismatched++;
        $display("[TB] FAIL stall_blocked c%0d: got %h want %h", c, {wr_busy, ramBus[13:8]},
                 {logic'(c != 0), 1'b1, 1'b0, 4'd3});
      end
      stepCycle();
    end
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
    nCompared++;
    if ({wr_busy, ramBus} !== {1'b1, 1'b1, 1'b1, 4'd5, 8'h07}) begin
      nMismatched++;
      $display("[TB] FAIL stall_steal: got %h want %h", {wr_busy, ramBus}, {1'b1, 1'b1, 1'b1, 4'd5, 8'h07});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    nCompared++;
    if ({wr_busy, ramBus[13:8]} !== {1'b0, 1'b1, 1'b0, 4'd5}) begin
      nMismatched++;
      $display("[TB] FAIL stall_busy_fall: got %h want %h", {wr_busy, ramBus[13:8]}, {1'b0, 1'b1, 1'b0, 4'd5});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if (rgbBus !== {1'b1, 4'hF, 4'hF, 4'hF}) begin
      nMismatched++;
      $display("[TB] FAIL stall_repeat: got %h want %h", rgbBus, {1'b1, 4'hF, 4'hF, 4'hF});
    end
    stepCycle();
    nCompared++;
    if (rgbBus !== {1'b1, 4'hF, 4'h0, 4'h0}) begin
      nMismatched++;
      $display("[TB] FAIL stall_newcolour: got %h want %h", rgbBus, {1'b1, 4'hF, 4'h0, 4'h0});
    end
    stepCycle();
  endtask

  task automatic test_last_write_wins();
    drive(1'b1, 4'd2, 8'h38, 1'b1, 4'd3);
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    stepCycle();
    drive(1'b1, 4'd2, 8'hC0, 1'b1, 4'd3);
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    nCompared++;
    if ({wr_busy, ram_wre} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL lww_not_yet: got %b want %b", {wr_busy, ram_wre}, 2'b10);
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    nCompared++;
    if (ramBus !== {1'b1, 1'b1, 4'd2, 8'hC0}) begin
      nMismatched++;
      $display("[TB] FAIL lww_steal: got %h want %h", ramBus, {1'b1, 1'b1, 4'd2, 8'hC0});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if (rgbBus !== {1'b1, 4'hF, 4'hF, 4'hF}) begin
      nMismatched++;
      $display("[TB] FAIL lww_repeat: got %h want %h", rgbBus, {1'b1, 4'hF, 4'hF, 4'hF});
    end
    stepCycle();
    nCompared++;
    if (rgbBus !== {1'b1, 4'h0, 4'h0, 4'hF}) begin
      nMismatched++;
      $display("[TB] FAIL lww_readback: got %h want %h", rgbBus, {1'b1, 4'h0, 4'h0, 4'hF});
    end
    stepCycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd7, 8'h05, 1'b0, 4'd0);
    stepCycle();
    drive(1'b1, 4'd8, 8'h28, 1'b0, 4'd0);
    nCompared++;
    if ({wr_busy, ramBus} !== {1'b1, 1'b1, 1'b1, 4'd7, 8'h05}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got %h want %h", {wr_busy, ramBus}, {1'b1, 1'b1, 1'b1, 4'd7, 8'h05});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    nCompared++;
    if ({wr_busy, ramBus[13:8]} !== {1'b1, 1'b1, 1'b0, 4'd7}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_held: got %h want %h", {wr_busy, ramBus[13:8]}, {1'b1, 1'b1, 1'b0, 4'd7});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if ({wr_busy, ramBus} !== {1'b1, 1'b1, 1'b1, 4'd8, 8'h28}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got %h want %h", {wr_busy, ramBus}, {1'b1, 1'b1, 1'b1, 4'd8, 8'h28});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd8);
    nCompared++;
    if ({wr_busy, rgbBus} !== {1'b0, 1'b1, 4'hB, 4'h0, 4'h0}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_red: got %h want %h", {wr_busy, rgbBus}, {1'b0, 1'b1, 4'hB, 4'h0, 4'h0});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    nCompared++;
    if (rgbBus !== 13'd0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_no_writethrough: got %h want %h", rgbBus, 13'd0);
    end
    stepCycle();
    nCompared++;
    if (rgbBus !== {1'b1, 4'h0, 4'hB, 4'h0}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_green: got %h want %h", rgbBus, {1'b1, 4'h0, 4'hB, 4'h0});
    end
    stepCycle();
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 4'd9, 8'hAA, 1'b1, 4'd3);
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    nCompared++;
    if ({wr_busy, rgbBus} !== {1'b1, 1'b1, 4'hF, 4'hF, 4'hF}) begin
      nMismatched++;
      $display("[TB] FAIL rst_pre: got %h want %h", {wr_busy, rgbBus}, {1'b1, 1'b1, 4'hF, 4'hF, 4'hF});
    end
    reset_n = 1'b0;
    #1;
    nCompared++;
    if ({wr_busy, rgbBus, ramBus} !== 28'd0) begin
      nMismatched++;
      $display("[TB] FAIL rst_async: got %h want %h", {wr_busy, rgbBus, ramBus}, 28'd0);
    end
    stepCycle();
    reset_n = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
    nCompared++;
    if ({wr_busy, rgbBus, ramBus[13:8]} !== {1'b0, 13'd0, 1'b1, 1'b0, 4'd9}) begin
      nMismatched++;
      $display("[TB] FAIL rst_after: got %h want %h", {wr_busy, rgbBus, ramBus[13:8]},
               {1'b0, 13'd0, 1'b1, 1'b0, 4'd9});
    end
    stepCycle();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    stepCycle();
    nCompared++;
    if (rgbBus !== {1'b1, 12'h000}) begin
      nMismatched++;
      $display("[TB] FAIL rst_ram_unchanged: got %h want %h", rgbBus, {1'b1, 12'h000});
    end
    stepCycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_last_write_wins();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
